// File: rtl/word_to_byte_if.sv
// Word-in / byte-out bundle for the word_to_byte serializer.
// The slave modport is the serializer; the master modport is its environment.
interface word_to_byte_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        k_out;

    modport master (
        output data_in, valid_in,
        input  ready_out, data_out, valid_out, k_out
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, data_out, valid_out, k_out
    );
endinterface

// File: rtl/word_to_byte.sv
// Serializes 32-bit words into bytes through a 2-entry FIFO; emits COM_SYM
// as a K symbol whenever no data byte is available.
module word_to_byte #(
    parameter logic [7:0] COM_SYM   = 8'hBC,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic            clk_8f,
    input  logic            reset,
    word_to_byte_if.slave   bus
);

    typedef enum logic {IDLE, SEND} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic [31:0] word_q, word_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        k_out_q, k_out_d;

    logic        push;
    logic        pop;
    logic [31:0] head;

    // Byte i in transmit order, i = 0 being the first byte on the wire.
    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
        logic [1:0] pos;
        pos = MSB_FIRST ? (2'd3 - i) : i;
        case (pos)
            2'd0:    pick_byte = w[7:0];
            2'd1:    pick_byte = w[15:8];
            2'd2:    pick_byte = w[23:16];
            default: pick_byte = w[31:24];
        endcase
    endfunction

    assign bus.ready_out = (count_q < 2'd2);
    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.k_out     = k_out_q;

    assign push = bus.valid_in && bus.ready_out;
    assign head = mem_q[rd_ptr_q];

    // Serializer: pop the head word when idle or when the last byte is leaving.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        word_d      = word_q;
        data_out_d  = COM_SYM;
        valid_out_d = 1'b0;
        k_out_d     = 1'b1;
        pop         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop         = 1'b1;
                    word_d      = head;
                    idx_d       = 2'd0;
                    state_d     = SEND;
                    data_out_d  = pick_byte(head, 2'd0);
                    valid_out_d = 1'b1;
                    k_out_d     = 1'b0;
                end
            end
            SEND: begin
                if (idx_q != 2'd3) begin
                    idx_d       = idx_q + 2'd1;
                    data_out_d  = pick_byte(word_q, idx_q + 2'd1);
                    valid_out_d = 1'b1;
                    k_out_d     = 1'b0;
                end else if (count_q != 2'd0) begin
                    pop         = 1'b1;
                    word_d      = head;
                    idx_d       = 2'd0;
                    data_out_d  = pick_byte(head, 2'd0);
                    valid_out_d = 1'b1;
                    k_out_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                    idx_d   = 2'd0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            word_q      <= '0;
            data_out_q  <= COM_SYM;
            valid_out_q <= 1'b0;
            k_out_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            word_q      <= word_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            k_out_q     <= k_out_d;
        end
    end

    // NOTE: the storage array has no reset; count_q gates every read, so stale
    // contents are never observed and the array can map to plain registers.
    always_ff @(posedge clk_8f) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_word_to_byte.sv
// Self-checking bench for word_to_byte: directed tables, hand-written corner
// sequences and random traffic against a queue-based reference model.
module tb_word_to_byte;

    localparam logic [7:0] COM = 8'hBC;

    logic clk_8f = 1'b0;
    logic reset  = 1'b0;

    word_to_byte_if bus();

    word_to_byte #(.COM_SYM(COM), .MSB_FIRST(1'b1)) dut (
        .clk_8f (clk_8f),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_8f = ~clk_8f;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word queue of at most two entries and a byte queue
    // holding the rest of the word currently on the wire.
    logic [31:0] mq[$];
    logic [7:0]  bq[$];
    logic [7:0]  exp_data;
    logic        exp_valid;
    logic        exp_k;
    logic        exp_ready;
    logic [7:0]  got_bytes[$];

    task automatic model_reset();
        mq.delete();
        bq.delete();
        exp_data  = COM;
        exp_valid = 1'b0;
        exp_k     = 1'b1;
        exp_ready = 1'b1;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d);
        bit          acc;
        logic [31:0] w;
        acc = v && (mq.size() < 2);
        if (bq.size() == 0 && mq.size() > 0) begin
            w = mq.pop_front();
            for (int i = 0; i < 4; i++) bq.push_back(w[31 - 8*i -: 8]);
        end
        if (bq.size() > 0) begin
            exp_data  = bq.pop_front();
            exp_valid = 1'b1;
            exp_k     = 1'b0;
        end else begin
            exp_data  = COM;
            exp_valid = 1'b0;
            exp_k     = 1'b1;
        end
        if (acc) mq.push_back(d);
        exp_ready = (mq.size() < 2);
    endtask

    // Drive inputs, advance the model and the DUT one edge, sample 1ns later.
    task automatic cycle(input bit v, input logic [31:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        model_edge(v, d);
        @(posedge clk_8f);
        #1;
        if (bus.valid_out === 1'b1) got_bytes.push_back(bus.data_out);
    endtask

    task automatic cycle_chk(input string tag, input bit v, input logic [31:0] d);
        cycle(v, d);
        check({tag, "_data"},  bus.data_out,  exp_data);
        check({tag, "_valid"}, bus.valid_out, exp_valid);
        check({tag, "_k"},     bus.k_out,     exp_k);
        check({tag, "_ready"}, bus.ready_out, exp_ready);
        check({tag, "_kxv"},   bus.k_out ^ bus.valid_out, 1'b1);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          rdy;
        bit          vo;
        bit          ko;
        logic [7:0]  dout;
    } vec_t;

    vec_t tbl[20];

    logic [7:0] exp_stream[$];
    int         stalls;
    bit         accepted;

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        model_reset();

        // Asynchronous reset, checked before the first clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_data",  bus.data_out,  COM);
        check("rst_valid", bus.valid_out, 1'b0);
        check("rst_k",     bus.k_out,     1'b1);
        check("rst_ready", bus.ready_out, 1'b1);
        @(posedge clk_8f);
        #1 reset = 1'b0;

        // Idle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 32'h0);
            check("idle_data",  bus.data_out,  8'hBC);
            check("idle_k",     bus.k_out,     1'b1);
            check("idle_valid", bus.valid_out, 1'b0);
            check("idle_ready", bus.ready_out, 1'b1);
        end

        // Single word then three back-to-back words; expectations after each edge.
        tbl[0]  = '{1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 8'hBC};
        tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hAA};
        tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hBB};
        tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hCC};
        tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'hDD};
        tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBC};
        tbl[6]  = '{1'b1, 32'h00010203, 1'b1, 1'b0, 1'b1, 8'hBC};
        tbl[7]  = '{1'b1, 32'h04050607, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 32'h08090A0B, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h02};
        tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 8'h03};
        tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h04};
        tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h05};
        tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h06};
        tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h07};
        tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h08};
        tbl[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h09};
        tbl[17] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h0A};
        tbl[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h0B};
        tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 8'hBC};
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].v, tbl[i].d);
            check($sformatf("tbl%0d_data", i),  bus.data_out,  tbl[i].dout);
            check($sformatf("tbl%0d_valid", i), bus.valid_out, tbl[i].vo);
            check($sformatf("tbl%0d_k", i),     bus.k_out,     tbl[i].ko);
            check($sformatf("tbl%0d_ready", i), bus.ready_out, tbl[i].rdy);
        end

        // Backpressure: fill the FIFO, then hold DEADBEEF until it is taken.
        got_bytes.delete();
        cycle_chk("bp_fill", 1'b1, 32'h01020304);
        cycle_chk("bp_fill", 1'b1, 32'h05060708);
        cycle_chk("bp_fill", 1'b1, 32'h090A0B0C);
        stalls   = 0;
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = (bus.ready_out === 1'b1);
            if (!accepted) stalls++;
            cycle_chk("bp_hold", 1'b1, 32'hDEADBEEF);
        end
        check("bp_accepted", accepted, 1'b1);
        check("bp_stalls", stalls, 3);
        for (int i = 0; i < 14; i++) cycle_chk("bp_drain", 1'b0, 32'h0);
        exp_stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                       8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check("bp_nbytes", got_bytes.size(), exp_stream.size());
        for (int i = 0; i < exp_stream.size() && i < got_bytes.size(); i++)
            check($sformatf("bp_byte%0d", i), got_bytes[i], exp_stream[i]);

        // Reset in the middle of a word, applied between edges.
        cycle_chk("mid", 1'b1, 32'h11223344);
        cycle_chk("mid", 1'b0, 32'h0);
        cycle_chk("mid", 1'b0, 32'h0);
        check("mid_byte1", bus.data_out, 8'h22);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("mid_rst_data",  bus.data_out,  8'hBC);
        check("mid_rst_k",     bus.k_out,     1'b1);
        check("mid_rst_valid", bus.valid_out, 1'b0);
        check("mid_rst_ready", bus.ready_out, 1'b1);
        @(posedge clk_8f);
        #1 reset = 1'b0;
        got_bytes.delete();
        for (int i = 0; i < 10; i++) cycle_chk("mid_after", 1'b0, 32'h0);
        check("mid_no_bytes", got_bytes.size(), 0);

        // Comma value carried as data.
        cycle_chk("com_push", 1'b1, 32'hBCBCBCBC);
        for (int i = 0; i < 4; i++) begin
            cycle_chk("com_byte", 1'b0, 32'h0);
            check("com_byte_data",  bus.data_out,  8'hBC);
            check("com_byte_valid", bus.valid_out, 1'b1);
            check("com_byte_k",     bus.k_out,     1'b0);
        end
        cycle_chk("com_idle", 1'b0, 32'h0);
        check("com_idle_k",     bus.k_out,     1'b1);
        check("com_idle_valid", bus.valid_out, 1'b0);

        // Random traffic against the model, occasionally seeding comma bytes.
        for (int i = 0; i < 1500; i++) begin
            bit          v;
            logic [31:0] d;
            v = ($urandom % 4) != 0;
            d = $urandom;
            if (($urandom % 8) == 0) d[15:8] = COM;
            cycle_chk("rand", v, d);
        end
        for (int i = 0; i < 12; i++) cycle_chk("rand_drain", 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
